// File: rtl/median_pkg.sv
// Shared pixel width default and 3-input compare helpers for the 3x3 median network.
// Helpers work on a wide unsigned type; callers zero-extend in and truncate out.
package median_pkg;

  localparam int unsigned PIX_DW = 8;
  localparam int unsigned MAX_DW = 32;

  typedef logic [MAX_DW-1:0] wpix_t;

  function automatic wpix_t max3(input wpix_t a, input wpix_t b, input wpix_t c);
    wpix_t m;
    m = (a >= b) ? a : b;
    return (m >= c) ? m : c;
  endfunction

  function automatic wpix_t min3(input wpix_t a, input wpix_t b, input wpix_t c);
    wpix_t m;
    m = (a >= b) ? b : a;
    return (m >= c) ? c : m;
  endfunction

  // mid = max(min(a,b), min(max(a,b), c))
  function automatic wpix_t mid3(input wpix_t a, input wpix_t b, input wpix_t c);
    wpix_t lo_ab;
    wpix_t hi_ab;
    wpix_t t;
    lo_ab = (a >= b) ? b : a;
    hi_ab = (a >= b) ? a : b;
    t     = (hi_ab >= c) ? c : hi_ab;
    return (lo_ab >= t) ? lo_ab : t;
  endfunction

endpackage

// File: rtl/sort3_reg.sv
// Registered 3-input sorter: one row of the median network's first stage.
module sort3_reg
  import median_pkg::*;
#(
  parameter int unsigned DW = PIX_DW
) (
  input  logic          sclk,
  input  logic          s_rst_n,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] c_i,
  output logic [DW-1:0] max_o,
  output logic [DW-1:0] mid_o,
  output logic [DW-1:0] min_o
);

  logic [DW-1:0] max_d, mid_d, min_d;
  logic [DW-1:0] max_q, mid_q, min_q;

  always_comb begin
    max_d = DW'(max3(MAX_DW'(a_i), MAX_DW'(b_i), MAX_DW'(c_i)));
    mid_d = DW'(mid3(MAX_DW'(a_i), MAX_DW'(b_i), MAX_DW'(c_i)));
    min_d = DW'(min3(MAX_DW'(a_i), MAX_DW'(b_i), MAX_DW'(c_i)));
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      max_q <= '0;
      mid_q <= '0;
      min_q <= '0;
    end else begin
      max_q <= max_d;
      mid_q <= mid_d;
      min_q <= min_d;
    end
  end

  assign max_o = max_q;
  assign mid_o = mid_q;
  assign min_o = min_q;

endmodule

// File: rtl/fast_median_core.sv
// 3-stage pipelined 3x3 median (row sort / column sort / diagonal) with
// per-frame coordinate tracking and centre-pixel passthrough on the image border.
module fast_median_core
  import median_pkg::*;
#(
  parameter int unsigned DW    = PIX_DW,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic          sclk,
  input  logic          s_rst_n,
  input  logic          vsync,
  input  logic          in_valid,
  input  logic [DW-1:0] d00,
  input  logic [DW-1:0] d01,
  input  logic [DW-1:0] d02,
  input  logic [DW-1:0] d10,
  input  logic [DW-1:0] d11,
  input  logic [DW-1:0] d12,
  input  logic [DW-1:0] d20,
  input  logic [DW-1:0] d21,
  input  logic [DW-1:0] d22,
  output logic          out_valid,
  output logic [DW-1:0] out_pixel,
  output logic          out_border
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Coordinate tracking
  logic          vsync_q;
  logic          frame_start_c;
  logic [CW-1:0] col_q, col_d, col_cur_c;
  logic [RW-1:0] row_q, row_d, row_cur_c;
  logic          border_c;

  assign frame_start_c = vsync & ~vsync_q;

  // A frame start forces the current pixel to (0,0) before the normal advance.
  always_comb begin
    col_cur_c = frame_start_c ? '0 : col_q;
    row_cur_c = frame_start_c ? '0 : row_q;
    border_c  = (col_cur_c == '0) | (col_cur_c == COL_LAST) |
                (row_cur_c == '0) | (row_cur_c == ROW_LAST);
    col_d     = col_cur_c;
    row_d     = row_cur_c;
    if (in_valid) begin
      if (col_cur_c == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur_c == ROW_LAST) ? '0 : row_cur_c + RW'(1);
      end else begin
        col_d = col_cur_c + CW'(1);
      end
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      vsync_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      vsync_q <= vsync;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Stage 1: row sort
  logic [2:0][DW-1:0] row_max, row_mid, row_min;

  sort3_reg #(.DW(DW)) u_sort_r0 (
    .sclk(sclk), .s_rst_n(s_rst_n), .a_i(d00), .b_i(d01), .c_i(d02),
    .max_o(row_max[0]), .mid_o(row_mid[0]), .min_o(row_min[0])
  );

  sort3_reg #(.DW(DW)) u_sort_r1 (
    .sclk(sclk), .s_rst_n(s_rst_n), .a_i(d10), .b_i(d11), .c_i(d12),
    .max_o(row_max[1]), .mid_o(row_mid[1]), .min_o(row_min[1])
  );

  sort3_reg #(.DW(DW)) u_sort_r2 (
    .sclk(sclk), .s_rst_n(s_rst_n), .a_i(d20), .b_i(d21), .c_i(d22),
    .max_o(row_max[2]), .mid_o(row_mid[2]), .min_o(row_min[2])
  );

  // Stage 2: column sort, stage 3: diagonal median and border select
  logic [DW-1:0]      lo_q, md_q, hi_q, lo_d, md_d, hi_d;
  logic [DW-1:0]      out_pixel_q, out_pixel_d;
  logic               out_border_q;
  logic [2:0]         valid_q;
  logic [1:0]         border_q;
  logic [1:0][DW-1:0] d11_q;

  always_comb begin
    lo_d = DW'(max3(MAX_DW'(row_min[0]), MAX_DW'(row_min[1]), MAX_DW'(row_min[2])));
    md_d = DW'(mid3(MAX_DW'(row_mid[0]), MAX_DW'(row_mid[1]), MAX_DW'(row_mid[2])));
    hi_d = DW'(min3(MAX_DW'(row_max[0]), MAX_DW'(row_max[1]), MAX_DW'(row_max[2])));
    out_pixel_d = border_q[1] ? d11_q[1]
                              : DW'(mid3(MAX_DW'(lo_q), MAX_DW'(md_q), MAX_DW'(hi_q)));
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      lo_q         <= '0;
      md_q         <= '0;
      hi_q         <= '0;
      out_pixel_q  <= '0;
      out_border_q <= 1'b0;
      valid_q      <= '0;
      border_q     <= '0;
      d11_q        <= '0;
    end else begin
      lo_q         <= lo_d;
      md_q         <= md_d;
      hi_q         <= hi_d;
      out_pixel_q  <= out_pixel_d;
      out_border_q <= border_q[1];
      valid_q      <= {valid_q[1:0], in_valid};
      border_q     <= {border_q[0], border_c};
      d11_q        <= {d11_q[0], d11};
    end
  end

  assign out_valid  = valid_q[2];
  assign out_pixel  = out_pixel_q;
  assign out_border = out_border_q;

endmodule

// File: tb/tb_fast_median_core.sv
// Directed bench for fast_median_core on an 8x8 image: median values, border
// passthrough, latency, gaps, frame control, wrap and asynchronous reset.
module tb_fast_median_core;

  localparam int unsigned DW = 8;

  logic          sclk = 1'b0;
  logic          s_rst_n;
  logic          vsync;
  logic          in_valid;
  logic [DW-1:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;
  logic          out_valid;
  logic [DW-1:0] out_pixel;
  logic          out_border;

  int n_checks = 0;
  int n_pass   = 0;

  fast_median_core #(.DW(DW), .IMG_W(8), .IMG_H(8)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .vsync(vsync), .in_valid(in_valid),
    .d00(d00), .d01(d01), .d02(d02), .d10(d10), .d11(d11), .d12(d12),
    .d20(d20), .d21(d21), .d22(d22),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_border(out_border)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [71:0] win(input int a, input int b, input int c,
                                      input int d, input int e, input int f,
                                      input int g, input int h, input int i);
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
  endfunction

  // Drive one cycle of inputs just after a falling edge, then move to the next one.
  task automatic push(input logic v, input logic vs, input logic [71:0] w);
    in_valid = v;
    vsync    = vs;
    {d00, d01, d02, d10, d11, d12, d20, d21, d22} = w;
    @(negedge sclk);
  endtask

  task automatic fill(input int n);
    for (int k = 0; k < n; k++) push(1'b1, 1'b0, '0);
  endtask

  task automatic vsync_pulse();
    push(1'b0, 1'b1, '0);
    push(1'b0, 1'b0, '0);
  endtask

  // One isolated pixel: idle, pixel, then output expected exactly three edges later.
  task automatic test_px(input string tag, input logic vs, input logic [71:0] w,
                         input int exp_pix, input int exp_bord);
    push(1'b0, 1'b0, '0);
    push(1'b1, vs, w);
    push(1'b0, 1'b0, '0);
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    push(1'b0, 1'b0, '0);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pix"},   32'(out_pixel), 32'(exp_pix));
    check({tag, "_bord"},  32'(out_border), 32'(exp_bord));
  endtask

  // Continuous valids (centre 200, rest 10) scored against an 8x8 coordinate model.
  task automatic stream(input int n, output int errs, output int seen, output int first,
                        output int last, output int bcnt, output logic last_b);
    int   pos;
    logic eb;
    errs = 0; seen = 0; first = -1; last = -1; bcnt = 0; last_b = 1'b0;
    for (int c = 0; c < n + 6; c++) begin
      push(c < n, 1'b0, win(10, 10, 10, 10, 200, 10, 10, 10, 10));
      if (out_valid) begin
        pos = seen % 64;
        eb  = (pos % 8 == 0) || (pos % 8 == 7) || (pos / 8 == 0) || (pos / 8 == 7);
        if (out_border !== eb || out_pixel !== (eb ? 8'd200 : 8'd10)) errs++;
        if (out_border) bcnt++;
        if (first < 0) first = c;
        last   = c;
        last_b = out_border;
        seen++;
      end
    end
  endtask

  initial begin
    int          errs, seen, first, last, bcnt;
    logic        last_b;
    logic [11:0] in_pat, out_pat, got_pat;
    int          stale;

    s_rst_n = 1'b0;
    vsync = 1'b0; in_valid = 1'b0;
    {d00, d01, d02, d10, d11, d12, d20, d21, d22} = '0;
    repeat (3) @(negedge sclk);
    check("rst_valid",  32'(out_valid),  32'd0);
    check("rst_pix",    32'(out_pixel),  32'd0);
    check("rst_border", 32'(out_border), 32'd0);
    s_rst_n = 1'b1;
    @(negedge sclk);

    // Interior pixels (3..6,3) and the right-edge pixel (7,3)
    vsync_pulse();
    fill(27);
    test_px("basic", 1'b0, win(9, 1, 5, 7, 3, 8, 2, 6, 4), 5, 0);
    test_px("tie_corners", 1'b0, win(0, 255, 255, 255, 255, 255, 255, 255, 0), 255, 0);
    test_px("five255", 1'b0, win(0, 0, 0, 0, 255, 255, 255, 255, 255), 255, 0);
    test_px("five0", 1'b0, win(255, 0, 255, 0, 0, 0, 255, 0, 255), 0, 0);
    test_px("col7", 1'b0, win(10, 10, 10, 10, 77, 10, 10, 10, 10), 77, 1);

    // New frame: (0,0) passes through, (1,1) is filtered
    vsync_pulse();
    test_px("col0", 1'b0, win(10, 10, 10, 10, 77, 10, 10, 10, 10), 77, 1);
    fill(8);
    test_px("c1r1", 1'b0, win(10, 10, 10, 10, 77, 10, 10, 10, 10), 10, 0);

    // vsync rising together with in_valid: that pixel is (0,0), next is (1,0)
    test_px("vs_valid", 1'b1, win(10, 10, 10, 10, 77, 10, 10, 10, 10), 77, 1);
    fill(8);
    test_px("vs_next", 1'b0, win(10, 20, 10, 10, 77, 10, 10, 30, 10), 10, 0);

    // Full 8x8 frame streamed back to back
    vsync_pulse();
    stream(64, errs, seen, first, last, bcnt, last_b);
    check("stream_errs",   32'(errs), 32'd0);
    check("stream_count",  32'(seen), 32'd64);
    check("stream_span",   32'(last - first + 1), 32'd64);
    check("stream_border", 32'(bcnt), 32'd28);

    // Two-cycle input gap reappears as a two-cycle output gap
    in_pat  = 12'b0000_1110_0111;
    out_pat = 12'b0011_1001_1100;
    got_pat = '0;
    for (int c = 0; c < 12; c++) begin
      push(in_pat[c], 1'b0, win(1, 2, 3, 4, 5, 6, 7, 8, 9));
      got_pat[c] = out_valid;
    end
    check("gap_pattern", 32'(got_pat), 32'(out_pat));

    // 74 valids with no vsync: counter wraps to (0,0) after 64, then (1,1) is interior
    vsync_pulse();
    stream(74, errs, seen, first, last, bcnt, last_b);
    check("wrap_errs",   32'(errs), 32'd0);
    check("wrap_count",  32'(seen), 32'd74);
    check("wrap_border", 32'(bcnt), 32'd37);
    check("wrap_last_b", 32'(last_b), 32'd0);

    // Reset with two pixels in flight
    push(1'b1, 1'b0, win(10, 10, 10, 10, 200, 10, 10, 10, 10));
    push(1'b1, 1'b0, win(10, 10, 10, 10, 200, 10, 10, 10, 10));
    in_valid = 1'b0;
    #2;
    check("pre_rst_pix", 32'(out_pixel != '0), 32'd1);
    s_rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_pix",   32'(out_pixel), 32'd0);
    repeat (2) @(negedge sclk);
    s_rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      push(1'b0, 1'b0, '0);
      if (out_valid) stale++;
    end
    check("rst_stale", 32'(stale), 32'd0);
    test_px("rst_first", 1'b0, win(10, 10, 10, 10, 77, 10, 10, 10, 10), 77, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
